// File: rtl/bnn_pkg.sv
// Shared types for the binary-CNN inference sequencer: sequencer states,
// stage indices into the one-hot stage_en vector, and widths.
package bnn_pkg;

  localparam int N_STAGES = 5;
  localparam int CLASS_W  = 4;

  localparam int STG_C1 = 0;
  localparam int STG_P1 = 1;
  localparam int STG_C2 = 2;
  localparam int STG_P2 = 3;
  localparam int STG_FC = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_C1,
    S_P1,
    S_C2,
    S_P2,
    S_FC,
    S_OUT
  } seq_state_e;

  // One-hot stage enable implied by a sequencer state (zero outside stages).
  function automatic logic [N_STAGES-1:0] stage_onehot(input seq_state_e s);
    logic [N_STAGES-1:0] oh;
    oh = '0;
    case (s)
      S_C1:    oh[STG_C1] = 1'b1;
      S_P1:    oh[STG_P1] = 1'b1;
      S_C2:    oh[STG_C2] = 1'b1;
      S_P2:    oh[STG_P2] = 1'b1;
      S_FC:    oh[STG_FC] = 1'b1;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/bnn_stage_timer.sv
// Shared stage timer: CNT_W-bit up-counter with synchronous clear and
// enable; done flags the last cycle of a stage of length lat.
module bnn_stage_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] lat,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // Count cycles spent in the current stage; clear has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= cnt + CNT_W'(1);
  end

  assign done = (cnt == (lat - CNT_W'(1)));

endmodule

// File: rtl/bnn_infer_sequencer.sv
// Inference controller for the binary CNN pipeline
// (18C5-P2-60C5-P2-FC10-argmax). Captures one image, steps the five
// stages with one-hot enables, latches the argmax class onto a
// valid/ready output and locks out weight writes while busy.
// Optional feature macro: BNN_SEQ_PERF_EN (inference cycle counter).
module bnn_infer_sequencer
  import bnn_pkg::*;
#(
  parameter int C1_LAT = 1,
  parameter int P1_LAT = 1,
  parameter int C2_LAT = 1,
  parameter int P2_LAT = 1,
  parameter int FC_LAT = 2,
  parameter int CNT_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                image_in_valid,
  output logic                image_in_ready,
  output logic                image_load,
  input  logic                kernel_in_valid,
  output logic                kernel_in_ready,
  output logic                kernel_wr_en,
  output logic [N_STAGES-1:0] stage_en,
  input  logic [CLASS_W-1:0]  class_in,
  output logic                class_out_valid,
  input  logic                class_out_ready,
  output logic [CLASS_W-1:0]  class_out,
  output logic                busy,
  output logic [15:0]         perf_cycles
);

  localparam int LAT_MAX = (1 << CNT_W) - 1;

  if ((C1_LAT < 1) || (C1_LAT > LAT_MAX)) begin : g_bad_c1
    $error("bnn_infer_sequencer: C1_LAT out of range");
  end
  if ((P1_LAT < 1) || (P1_LAT > LAT_MAX)) begin : g_bad_p1
    $error("bnn_infer_sequencer: P1_LAT out of range");
  end
  if ((C2_LAT < 1) || (C2_LAT > LAT_MAX)) begin : g_bad_c2
    $error("bnn_infer_sequencer: C2_LAT out of range");
  end
  if ((P2_LAT < 1) || (P2_LAT > LAT_MAX)) begin : g_bad_p2
    $error("bnn_infer_sequencer: P2_LAT out of range");
  end
  if ((FC_LAT < 1) || (FC_LAT > LAT_MAX)) begin : g_bad_fc
    $error("bnn_infer_sequencer: FC_LAT out of range");
  end

  seq_state_e       state, state_n;
  logic [CNT_W-1:0] lat;
  logic             in_stage;
  logic             stage_done;
  logic             fc_done;
  logic             out_hs;

  // Handshakes: weight writes win over image accept in IDLE.
  assign kernel_in_ready = (state == S_IDLE);
  assign kernel_wr_en    = kernel_in_valid & kernel_in_ready;
  assign image_in_ready  = (state == S_IDLE) & ~kernel_in_valid;
  assign image_load      = image_in_valid & image_in_ready;
  assign busy            = (state != S_IDLE);
  assign in_stage        = (state == S_C1) | (state == S_P1) | (state == S_C2) |
                           (state == S_P2) | (state == S_FC);
  assign fc_done         = (state == S_FC) & stage_done;
  assign out_hs          = (state == S_OUT) & class_out_ready;

  // Select the active stage's latency for the shared timer.
  always_comb begin
    lat = CNT_W'(1);
    case (state)
      S_C1:    lat = CNT_W'(C1_LAT);
      S_P1:    lat = CNT_W'(P1_LAT);
      S_C2:    lat = CNT_W'(C2_LAT);
      S_P2:    lat = CNT_W'(P2_LAT);
      S_FC:    lat = CNT_W'(FC_LAT);
      default: lat = CNT_W'(1);
    endcase
  end

  bnn_stage_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (stage_done | ~in_stage),
    .en   (in_stage),
    .lat  (lat),
    .done (stage_done)
  );

  // Next-state: advance through stages on timer done, wait in OUT for ready.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (image_load) state_n = S_C1;
      S_C1:    if (stage_done) state_n = S_P1;
      S_P1:    if (stage_done) state_n = S_C2;
      S_C2:    if (stage_done) state_n = S_P2;
      S_P2:    if (stage_done) state_n = S_FC;
      S_FC:    if (stage_done) state_n = S_OUT;
      S_OUT:   if (class_out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // State and stage enable register; stage_en is decoded from the next
  // state so it is registered yet aligned with the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      stage_en <= '0;
    end else begin
      state    <= state_n;
      stage_en <= stage_onehot(state_n);
    end
  end

  // Result register: capture on the last FC cycle, release on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      class_out       <= '0;
      class_out_valid <= 1'b0;
    end else if (fc_done) begin
      class_out       <= class_in;
      class_out_valid <= 1'b1;
    end else if (out_hs) begin
      class_out_valid <= 1'b0;
    end
  end

`ifdef BNN_SEQ_PERF_EN
  // Inference cycle counter: clear on accept, count busy cycles, saturate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    perf_cycles <= '0;
    else if (image_load)                        perf_cycles <= '0;
    else if (busy && (perf_cycles != 16'hFFFF)) perf_cycles <= perf_cycles + 16'd1;
  end
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_bnn_infer_sequencer.sv
// Self-checking bench for bnn_infer_sequencer: default-latency instance
// plus a C1_LAT=3/FC_LAT=1 instance, randomized classes/stalls/weight
// requests checked against a stage-schedule reference model.
module tb_bnn_infer_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        image_in_valid, image_in_ready, image_load;
  logic        kernel_in_valid, kernel_in_ready, kernel_wr_en;
  logic [4:0]  stage_en;
  logic [3:0]  class_in, class_out;
  logic        class_out_valid, class_out_ready, busy;
  logic [15:0] perf_cycles;

  logic        d2_image_in_valid, d2_image_in_ready, d2_image_load;
  logic        d2_kernel_in_valid, d2_kernel_in_ready, d2_kernel_wr_en;
  logic [4:0]  d2_stage_en;
  logic [3:0]  d2_class_in, d2_class_out;
  logic        d2_class_out_valid, d2_class_out_ready, d2_busy;
  logic [15:0] d2_perf_cycles;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bnn_infer_sequencer dut (
    .clk(clk), .rst(rst),
    .image_in_valid(image_in_valid), .image_in_ready(image_in_ready), .image_load(image_load),
    .kernel_in_valid(kernel_in_valid), .kernel_in_ready(kernel_in_ready), .kernel_wr_en(kernel_wr_en),
    .stage_en(stage_en), .class_in(class_in), .class_out_valid(class_out_valid),
    .class_out_ready(class_out_ready), .class_out(class_out), .busy(busy), .perf_cycles(perf_cycles)
  );

  bnn_infer_sequencer #(.C1_LAT(3), .FC_LAT(1)) dut2 (
    .clk(clk), .rst(rst),
    .image_in_valid(d2_image_in_valid), .image_in_ready(d2_image_in_ready), .image_load(d2_image_load),
    .kernel_in_valid(d2_kernel_in_valid), .kernel_in_ready(d2_kernel_in_ready), .kernel_wr_en(d2_kernel_wr_en),
    .stage_en(d2_stage_en), .class_in(d2_class_in), .class_out_valid(d2_class_out_valid),
    .class_out_ready(d2_class_out_ready), .class_out(d2_class_out), .busy(d2_busy), .perf_cycles(d2_perf_cycles)
  );

  // Reference model: per-cycle stage schedule built from stage latencies.
  function automatic void build_sched(input int l0, input int l1, input int l2,
                                      input int l3, input int l4, output logic [4:0] q[$]);
    int lats[5];
    lats = '{l0, l1, l2, l3, l4};
    q = {};
    for (int s = 0; s < 5; s++)
      for (int k = 0; k < lats[s]; k++) q.push_back(5'(1 << s));
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk); #1;
    checks++; if (stage_en !== 5'h00) begin errors++; $display("FAIL reset_stage_en got %h exp 00", stage_en); end
    checks++; if (class_out_valid !== 1'b0 || class_out !== 4'h0) begin errors++; $display("FAIL reset_class got v=%b c=%h exp v=0 c=0", class_out_valid, class_out); end
    checks++; if (busy !== 1'b0 || perf_cycles !== 16'h0) begin errors++; $display("FAIL reset_busy_perf got %b %h exp 0 0000", busy, perf_cycles); end
    checks++; if (image_in_ready !== 1'b1 || kernel_in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got img=%b ker=%b exp 1 1", image_in_ready, kernel_in_ready); end
    checks++; if (d2_stage_en !== 5'h00 || d2_class_out_valid !== 1'b0) begin errors++; $display("FAIL reset_dut2 got se=%h v=%b exp 00 0", d2_stage_en, d2_class_out_valid); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One full inference on the default-latency instance.
  task automatic run_inference(input logic [3:0] cls, input int stall, input bit kv);
    logic [4:0] sched[$];
    int total;
    build_sched(1, 1, 1, 1, 2, sched);
    total = sched.size();
    @(negedge clk);
    class_in = cls;
    image_in_valid = 1'b1;
    #1;
    checks++; if (image_load !== 1'b1) begin errors++; $display("FAIL accept_load got %b exp 1", image_load); end
    for (int i = 0; i < total; i++) begin
      @(negedge clk);
      if (i == 0) begin image_in_valid = 1'b0; kernel_in_valid = kv; end
      #1;
      checks++; if (stage_en !== sched[i]) begin errors++; $display("FAIL stage_seq[%0d] got %h exp %h", i, stage_en, sched[i]); end
      checks++; if (class_out_valid !== 1'b0 || busy !== 1'b1 || image_in_ready !== 1'b0 ||
                    kernel_in_ready !== 1'b0 || kernel_wr_en !== 1'b0) begin
        errors++; $display("FAIL busy_flags[%0d] got v=%b b=%b ir=%b kr=%b kw=%b exp 0 1 0 0 0",
                           i, class_out_valid, busy, image_in_ready, kernel_in_ready, kernel_wr_en);
      end
    end
    @(negedge clk); #1;
    checks++; if (class_out_valid !== 1'b1 || class_out !== cls) begin errors++; $display("FAIL result got v=%b c=%h exp v=1 c=%h", class_out_valid, class_out, cls); end
    checks++; if (stage_en !== 5'h00 || kernel_wr_en !== 1'b0) begin errors++; $display("FAIL out_state got se=%h kw=%b exp 00 0", stage_en, kernel_wr_en); end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk); #1;
      checks++; if (class_out_valid !== 1'b1 || class_out !== cls || busy !== 1'b1) begin
        errors++; $display("FAIL stall_hold[%0d] got v=%b c=%h b=%b exp 1 %h 1", s, class_out_valid, class_out, busy, cls);
      end
    end
    class_out_ready = 1'b1;
    @(negedge clk);
    class_out_ready = 1'b0;
    #1;
    checks++; if (class_out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL release got v=%b b=%b exp 0 0", class_out_valid, busy); end
    checks++; if (image_in_ready !== !kv || kernel_wr_en !== kv) begin errors++; $display("FAIL idle_ready got ir=%b kw=%b exp %b %b", image_in_ready, kernel_wr_en, !kv, kv); end
`ifdef BNN_SEQ_PERF_EN
    checks++; if (perf_cycles !== 16'(total + stall + 1)) begin errors++; $display("FAIL perf got %0d exp %0d", perf_cycles, total + stall + 1); end
`else
    checks++; if (perf_cycles !== 16'h0) begin errors++; $display("FAIL perf_off got %0d exp 0", perf_cycles); end
`endif
    kernel_in_valid = 1'b0;
  endtask

  task automatic test_defaults();
    run_inference(4'd7, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_inference(4'd11, 20, 1'b0);
  endtask

  task automatic test_weight_lockout();
    run_inference(4'd2, 3, 1'b1);
    @(negedge clk);
    image_in_valid = 1'b1;
    kernel_in_valid = 1'b1;
    #1;
    checks++; if (kernel_wr_en !== 1'b1 || image_load !== 1'b0 || image_in_ready !== 1'b0) begin
      errors++; $display("FAIL kernel_priority got kw=%b il=%b ir=%b exp 1 0 0", kernel_wr_en, image_load, image_in_ready);
    end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0 || stage_en !== 5'h00) begin errors++; $display("FAIL no_accept got b=%b se=%h exp 0 00", busy, stage_en); end
    image_in_valid = 1'b0;
    kernel_in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_fc();
    run_inference(4'd13, 0, 1'b0);
    @(negedge clk);
    class_in = 4'd9;
    image_in_valid = 1'b1;
    @(negedge clk);
    image_in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checks++; if (stage_en !== 5'h10) begin errors++; $display("FAIL pre_reset_fc got %h exp 10", stage_en); end
    rst = 1'b1;
    #1;
    checks++; if (stage_en !== 5'h00 || class_out !== 4'h0 || class_out_valid !== 1'b0 ||
                  busy !== 1'b0 || perf_cycles !== 16'h0 || kernel_in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset got se=%h c=%h v=%b b=%b p=%h kr=%b exp 00 0 0 0 0000 1",
                         stage_en, class_out, class_out_valid, busy, perf_cycles, kernel_in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    run_inference(4'd3, 0, 1'b0);
  endtask

  task automatic test_custom_latency();
    logic [4:0] sched[$];
    logic [3:0] cls;
    cls = 4'($urandom_range(0, 9));
    build_sched(3, 1, 1, 1, 1, sched);
    @(negedge clk);
    d2_class_in = cls;
    d2_image_in_valid = 1'b1;
    for (int i = 0; i < sched.size(); i++) begin
      @(negedge clk);
      d2_image_in_valid = 1'b0;
      #1;
      checks++; if (d2_stage_en !== sched[i] || d2_class_out_valid !== 1'b0) begin
        errors++; $display("FAIL lat_seq[%0d] got se=%h v=%b exp %h 0", i, d2_stage_en, d2_class_out_valid, sched[i]);
      end
    end
    @(negedge clk); #1;
    checks++; if (d2_class_out_valid !== 1'b1 || d2_class_out !== cls) begin errors++; $display("FAIL lat_result got v=%b c=%h exp 1 %h", d2_class_out_valid, d2_class_out, cls); end
    d2_class_out_ready = 1'b1;
    @(negedge clk);
    d2_class_out_ready = 1'b0;
    #1;
    checks++; if (d2_class_out_valid !== 1'b0 || d2_image_in_ready !== 1'b1) begin errors++; $display("FAIL lat_release got v=%b ir=%b exp 0 1", d2_class_out_valid, d2_image_in_ready); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++)
      run_inference(4'($urandom_range(0, 9)), int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    image_in_valid = 1'b0; kernel_in_valid = 1'b0; class_in = '0; class_out_ready = 1'b0;
    d2_image_in_valid = 1'b0; d2_kernel_in_valid = 1'b0; d2_class_in = '0; d2_class_out_ready = 1'b0;
    test_reset();
    test_defaults();
    test_backpressure();
    test_weight_lockout();
    test_reset_mid_fc();
    test_custom_latency();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
